// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit for the EX stage.
// Serves MULT, MULTU, DIV and DIVU at one bit per cycle, plus MTHI/MTLO.
// It owns the architectural HI/LO registers.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_start, i_op       issue (IDLE only); op 00 MULT 01 MULTU 10 DIV 11 DIVU
//   i_mthi, i_mtlo      write operando_A into HI / LO (IDLE, no start)
//   operando_A/B        operands, sampled only in the start cycle
//   o_busy              operation in progress (NBITS cycles)
//   o_done              one-cycle pulse when HI/LO take a new result
//   o_hi, o_lo          HI (upper product / remainder), LO (lower / quotient)
module mult_div_unit #(
  parameter int NBITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  input  logic [NBITS-1:0] operando_A,
  input  logic [NBITS-1:0] operando_B,
  output logic             o_busy,
  output logic             o_done,
  output logic [NBITS-1:0] o_hi,
  output logic [NBITS-1:0] o_lo
);

  localparam int CW = $clog2(NBITS);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r;
  // Shared datapath: for multiply {acc_hi,acc_lo} is the product with the
  // multiplier shifting out of acc_lo; for divide acc_hi is the partial
  // remainder and acc_lo shifts the dividend out and the quotient in.
  logic [NBITS-1:0] acc_hi, acc_lo, opb;

  logic             sgn_a, sgn_b, last;
  logic [NBITS-1:0] mag_a, mag_b;
  logic [NBITS:0]   mul_sum, rem_sh, trial;
  logic             q_bit;
  logic [NBITS-1:0] step_hi, step_lo, res_hi, res_lo;
  logic [2*NBITS-1:0] prod;

  // Operand sign/magnitude; only MULT and DIV (i_op[0]==0) are signed.
  assign sgn_a = ~i_op[0] & operando_A[NBITS-1];
  assign sgn_b = ~i_op[0] & operando_B[NBITS-1];
  assign mag_a = sgn_a ? -operando_A : operando_A;
  assign mag_b = sgn_b ? -operando_B : operando_B;

  // One shift-add step.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);

  // One restoring-division step; a zero divisor yields all-ones quotient
  // and leaves the dividend as remainder without special casing.
  assign rem_sh = {acc_hi, acc_lo[NBITS-1]};
  assign trial  = rem_sh - {1'b0, opb};
  assign q_bit  = ~trial[NBITS];

  always_comb begin
    step_hi = mul_sum[NBITS:1];
    step_lo = {mul_sum[0], acc_lo[NBITS-1:1]};
    if (is_div) begin
      step_hi = q_bit ? trial[NBITS-1:0] : rem_sh[NBITS-1:0];
      step_lo = {acc_lo[NBITS-2:0], q_bit};
    end
  end

  // Sign fix-up applied as the final step is written to HI/LO.
  always_comb begin
    prod   = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
    res_hi = prod[2*NBITS-1:NBITS];
    res_lo = prod[NBITS-1:0];
    if (is_div) begin
      res_hi = neg_r ? -step_hi : step_hi;
      res_lo = neg_q ? -step_lo : step_lo;
    end
  end

  assign last   = (state == CALC) && (cnt == CW'(NBITS - 1));
  assign o_busy = (state == CALC);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (i_start) state_nx = CALC;
      CALC:    if (last)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opb    <= '0;
      o_done <= 1'b0;
      o_hi   <= '0;
      o_lo   <= '0;
    end else begin
      state  <= state_nx;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            cnt    <= '0;
            is_div <= i_op[1];
            acc_hi <= '0;
            if (i_op[1]) begin
              acc_lo <= mag_a;
              opb    <= mag_b;
              // Divide-by-zero keeps the all-ones quotient unsigned.
              neg_q  <= (sgn_a ^ sgn_b) & (operando_B != '0);
              neg_r  <= sgn_a;
            end else begin
              acc_lo <= mag_b;
              opb    <= mag_a;
              neg_q  <= sgn_a ^ sgn_b;
              neg_r  <= 1'b0;
            end
          end else begin
            if (i_mthi) o_hi <= operando_A;
            if (i_mtlo) o_lo <= operando_A;
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          if (last) begin
            o_hi   <= res_hi;
            o_lo   <= res_lo;
            o_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_start, i_mthi, i_mtlo;
  logic [1:0]   i_op;
  logic [N-1:0] a, b;
  logic         o_busy, o_done;
  logic [N-1:0] o_hi, o_lo;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  mult_div_unit #(.NBITS(N)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_op(i_op),
    .i_mthi(i_mthi), .i_mtlo(i_mtlo), .operando_A(a), .operando_B(b),
    .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference arithmetic straight from the operation definitions.
  function automatic void calc(input logic [1:0] op, input logic [N-1:0] x,
                               input logic [N-1:0] y,
                               output logic [N-1:0] hi, output logic [N-1:0] lo);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      2'b00: begin p = 64'(sx * sy); hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin p = 64'(x) * 64'(y); hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (y == 0) begin
          lo = '1; hi = x;
        end else if (op == 2'b10) begin
          q = sx / sy; r = sx % sy;
          lo = q[31:0]; hi = r[31:0];
        end else begin
          lo = x / y; hi = x % y;
        end
      end
    endcase
  endfunction

  // Cycle-level model: result appears N edges after the accepted start.
  logic         m_busy, m_done;
  logic [N-1:0] m_hi, m_lo, p_hi, p_lo;
  int           m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_hi = p_hi; m_lo = p_lo;
        end
      end else if (i_start) begin
        calc(i_op, a, b, p_hi, p_lo);
        m_left = N; m_busy = 1;
      end else begin
        if (i_mthi) m_hi = a;
        if (i_mtlo) m_lo = a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(o_busy), 64'(m_busy));
      check("done", 64'(o_done), 64'(m_done));
      check("hi",   64'(o_hi),   64'(m_hi));
      check("lo",   64'(o_lo),   64'(m_lo));
    end
  end

  // Issue while in IDLE; the edge that samples the start is E0.
  task automatic issue(input logic [1:0] op, input logic [N-1:0] x, input logic [N-1:0] y);
    i_start = 1; i_op = op; a = x; b = y;
    @(posedge clk); #1;
    i_start = 0; a = 32'hDEAD_BEEF; b = 32'h5A5A_A5A5;
  endtask

  // Wait for done (bounded), then pin latency and the literal result.
  task automatic wait_done(input string name, input int lat,
                           input logic [N-1:0] ehi, input logic [N-1:0] elo);
    int cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!o_done && cyc < 40);
    check({name, "_lat"}, 64'(cyc), 64'(lat));
    check({name, "_hi"}, 64'(o_hi), 64'(ehi));
    check({name, "_lo"}, 64'(o_lo), 64'(elo));
  endtask

  initial begin
    int ndone;
    reset = 1; i_start = 0; i_op = 0; i_mthi = 0; i_mtlo = 0; a = '0; b = '0;
    @(posedge clk); #1; chk_en = 1;
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_done", 64'(o_done), 64'(0));
    check("rst_hi", 64'(o_hi), 64'(0));
    check("rst_lo", 64'(o_lo), 64'(0));

    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu_ff", 33, 32'h1, 32'hFFFF_FFFE);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    issue(2'b11, 32'd100, 32'd7);           // back-to-back from done cycle
    wait_done("divu_b2b", 33, 32'd2, 32'd14);

    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 33, 32'h0, 32'h8000_0000);
    issue(2'b11, 32'h1234, 32'h0);
    wait_done("divu_z", 33, 32'h1234, 32'hFFFF_FFFF);
    issue(2'b10, 32'hFFFF_FFFB, 32'h0);
    wait_done("div_z", 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", 33, 32'h4000_0000, 32'h0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max", 33, 32'hFFFF_FFFE, 32'h1);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    wait_done("div_pos_neg", 33, 32'd1, 32'hFFFF_FFFD);

    // Start and MTHI while busy are both ignored.
    @(posedge clk); #1;
    issue(2'b01, 32'd5, 32'd5);
    repeat (9) @(posedge clk); #1;
    i_start = 1; i_op = 2'b11; a = 32'hAA; b = 32'd3; i_mthi = 1;
    @(posedge clk); #1;
    i_start = 0; i_mthi = 0;
    wait_done("busy_ign", 23, 32'd0, 32'd25);

    // Both move-to writes in one IDLE cycle, no done pulse.
    @(posedge clk); #1;
    i_mthi = 1; i_mtlo = 1; a = 32'hAA;
    @(posedge clk); #1;
    i_mthi = 0; i_mtlo = 0; a = '0;
    @(negedge clk);
    check("mt_hi", 64'(o_hi), 64'hAA);
    check("mt_lo", 64'(o_lo), 64'hAA);
    check("mt_done", 64'(o_done), 64'(0));

    // Reset mid-operation aborts with no done pulse.
    @(posedge clk); #1;
    issue(2'b00, 32'd12, 32'hFFFF_FFF0);
    repeat (14) @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("abort_busy", 64'(o_busy), 64'(0));
    check("abort_hi", 64'(o_hi), 64'(0));
    check("abort_lo", 64'(o_lo), 64'(0));
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
